// File: rtl/uart_tx_buffered_if.sv
// Byte-write side and status/serial outputs of the buffered UART transmitter.
// The master drives the write strobe and byte; the slave reports FIFO and line state.
interface uart_tx_buffered_if;
    logic [7:0] din;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       overrun;
    logic       busy;
    logic       TX;

    modport master (
        output din, wr_en,
        input  full, empty, overrun, busy, TX
    );

    modport slave (
        input  din, wr_en,
        output full, empty, overrun, busy, TX
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small byte FIFO, one bit per OVERSAMPLE clocks.
// Back-to-back frames chain directly from the last stop cycle into the next start.
module uart_tx_buffered #(
    parameter int DEPTH      = 4,
    parameter int OVERSAMPLE = 16
) (
    input logic               clk1,
    input logic               reset,
    uart_tx_buffered_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [BW-1:0] BMAX = BW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovr_q;

    state_e        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          tx_q;
    logic          busy_q;

    logic full, empty, wr_ok, bit_end, pop;

    // Status is taken from the occupancy before the edge.
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign wr_ok   = bus.wr_en & ~full;
    assign bit_end = (baud_q == BMAX);
    assign pop     = ~empty & ((state_q == IDLE) |
                               ((state_q == STOP) & bit_end));

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
    end

    always_ff @(posedge clk1) begin
        if (!reset && wr_ok)
            mem_q[wptr_q] <= bus.din;
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (wr_ok)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_d;
            ovr_q <= bus.wr_en & full;
        end
    end

    // Shift register is loaded only on entry to START and only indexed afterwards.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shreg_q <= mem_q[rptr_q];
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shreg_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        bit_q  <= '0;
                        if (pop) begin
                            shreg_q <= mem_q[rptr_q];
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.overrun = ovr_q;
    assign bus.busy    = busy_q;
    assign bus.TX      = tx_q;
endmodule
